spi_lcd_sequencer: RTL and testbench
====================================

// Module: spi_lcd_sequencer
// PURPOSE
//  Instruction-driven SPI transmit sequencer for an LCD (MOSI, CS, D/C) with on-chip program memory.
//  Combines a write-loadable instruction RAM, a fetch/decode/shift FSM and a MOSI output flop.
//  Sits between serialClock (provides sclk edge strobes) and the gpio pins.
//  Replaces the separate memory/finiteStateMachine/mosiFF blocks.
// PARAMETERS
//  MEM_BITS    10  instruction word width: [9:8] opcode, [7:0] operand
//  ADDR_WIDTH  8   program-counter / memory address width (depth = 2**ADDR_WIDTH)
//  DATA_BITS   8   SPI byte width
// PORTS
//  clk            in   1           system clock; all state changes on rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  sclk_pos_edge  in   1           1-clk strobe: SPI clock rising edge (sample edge)
//  sclk_neg_edge  in   1           1-clk strobe: SPI clock falling edge (launch edge)
//  start          in   1           1-clk pulse: run program from address 0
//  wr_en          in   1           memory write enable (honoured only while busy=0)
//  wr_addr        in   ADDR_WIDTH  memory write address
//  wr_data        in   MEM_BITS    memory write data
//  mosi           out  1           serial data, MSB first
//  cs             out  1           chip select, active low
//  dc             out  1           data/command: 0=command, 1=data
//  busy           out  1           program running
//  done           out  1           HALT reached; held until next start
//  pc             out  ADDR_WIDTH  current program counter
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=0, cs=1, dc=0, mosi=0, busy=0, done=0. RAM contents not reset.
//  Memory: synchronous write on clk if wr_en && !busy. Synchronous read at pc; data valid 1 clk later.
//  Opcodes: 00=CMD (send operand, dc=0); 01=DATA (send operand, dc=1);
//   10=DELAY (wait operand sclk_pos_edges, cs high); 11=HALT.
//  States:
//   IDLE:   start -> FETCH, busy=1, done=0, pc=0.
//   FETCH:  1 clk (RAM read latency) -> DECODE.
//   DECODE: 1 clk.
//    CMD/DATA: load shift reg with operand, set dc -> SHIFT.
//    DELAY: load counter with operand; 0 -> pc+1, FETCH; else -> DELAY.
//    HALT -> HALT.
//   SHIFT:
//    1st sclk_neg_edge: cs=0, mosi=bit7.
//    Each following sclk_neg_edge while bits remain: mosi=next bit.
//    Bit counter advances on each sclk_pos_edge.
//    First sclk_neg_edge after the 8th sclk_pos_edge: cs=1, pc=pc+1 -> FETCH.
//    mosi holds last bit.
//   DELAY:  counter -1 per sclk_pos_edge; when it reaches 0 -> pc=pc+1, FETCH.
//   HALT:   busy=0, done=1, cs=1; start -> pc=0, FETCH, done=0.
//  mosi is a register updated only on clks with sclk_neg_edge=1. No combinational path to pins.
//  dc changes only in DECODE, while cs=1.
//  pc wraps from 2**ADDR_WIDTH-1 to 0.
//  start is ignored while busy=1.
//  If both strobes are asserted in one clk, sclk_pos_edge is processed and sclk_neg_edge is ignored.
//  Reset mid-transfer: cs returns high immediately (asynchronously); the program is abandoned.
// TESTING
//  1. Reset: with rst_n=0, require cs=1, mosi=0, dc=0, busy=0, done=0, pc=0.
//  2. Load [0]=0x0A5 (CMD A5), [1]=0x3C0 (HALT); pulse start.
//     Require cs=0 for exactly 8 sclk periods, dc=0, MOSI 1,0,1,0,0,1,0,1; then done=1, pc=1.
//  3. Load [0]=0x13C (DATA 3C), [1]=0x1FF (DATA FF), [2]=0x300.
//     Require dc=1, bytes 3C then FF, cs high between bytes; final pc=2.
//  4. Load [0]=0x205 (DELAY 5), [1]=0x300: require cs=1 throughout, done after 5 sclk_pos_edges (+ fetch cycles).
//     Repeat with DELAY 0: no wait.
//  5. Assert wr_en while busy=1: RAM unchanged. Pulse start mid-run: ignored.
//     Pulse rst_n low mid-byte: cs=1 immediately.
//  6. ADDR_WIDTH=2, no HALT in memory: require pc to wrap 3->0 and execution to continue.

Source files
------------

// File: rtl/spi_lcd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_lcd_sequencer
//
// Instruction-driven SPI transmit sequencer for an LCD panel. A small program
// held in on-chip RAM is fetched, decoded and executed; each instruction either
// shifts one byte out on MOSI (as a command or as data), waits a number of SPI
// clock periods with CS released, or halts. SPI clock edges are supplied as
// single-cycle strobes by an external serial clock generator.
//
// Instruction word: [MEM_BITS-1:MEM_BITS-2] opcode, [DATA_BITS-1:0] operand
//   00 CMD   : send operand with dc=0
//   01 DATA  : send operand with dc=1
//   10 DELAY : wait operand sclk rising edges, CS high
//   11 HALT  : stop, raise done
//
// Ports
//   clk            in   system clock, all state changes on rising edge
//   rst_n          in   asynchronous active-low reset
//   sclk_pos_edge  in   1-clk strobe, SPI sample edge
//   sclk_neg_edge  in   1-clk strobe, SPI launch edge
//   start          in   1-clk pulse, run program from address 0
//   wr_en          in   program RAM write enable (ignored while busy)
//   wr_addr        in   program RAM write address
//   wr_data        in   program RAM write data
//   mosi           out  serial data, MSB first (registered)
//   cs             out  chip select, active low (registered)
//   dc             out  data/command select, 0=command 1=data (registered)
//   busy           out  program running
//   done           out  HALT reached, held until next start
//   pc             out  current program counter
// -----------------------------------------------------------------------------
module spi_lcd_sequencer #(
  parameter int MEM_BITS   = 10,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk_pos_edge,
  input  logic                  sclk_neg_edge,
  input  logic                  start,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [MEM_BITS-1:0]   wr_data,
  output logic                  mosi,
  output logic                  cs,
  output logic                  dc,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int BCNT_W = $clog2(DATA_BITS + 1);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE    = ADDR_WIDTH'(1);
  localparam logic [BCNT_W-1:0]     BCNT_ONE  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0]     BCNT_FULL = BCNT_W'(DATA_BITS);
  localparam logic [DATA_BITS-1:0]  DLY_ONE   = DATA_BITS'(1);

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SHIFT,
    S_DELAY,
    S_HALT
  } state_t;

  // Program memory and its registered read port
  logic [MEM_BITS-1:0] mem_q [DEPTH];
  logic [MEM_BITS-1:0] rd_q;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic [DATA_BITS-1:0]  dly_q, dly_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic                  started_q, started_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_q, cs_d;
  logic                  dc_q, dc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  pos_ev;
  logic                  neg_ev;
  logic [1:0]            opcode;
  logic [DATA_BITS-1:0]  operand;

  // A coincident pair of strobes is treated as a rising edge only.
  assign pos_ev  = sclk_pos_edge;
  assign neg_ev  = sclk_neg_edge & ~sclk_pos_edge;

  assign opcode  = rd_q[MEM_BITS-1 -: 2];
  assign operand = rd_q[DATA_BITS-1:0];

  // RAM: writes locked out while a program runs; read data lags pc by one clk,
  // which is what the FETCH state waits for.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_q <= mem_q[pc_q];
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    shreg_d   = shreg_q;
    dly_d     = dly_q;
    bcnt_d    = bcnt_q;
    started_d = started_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    dc_d      = dc_q;
    busy_d    = busy_q;
    done_d    = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end

      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        unique case (opcode)
          OP_CMD, OP_DATA: begin
            shreg_d   = operand;
            dc_d      = (opcode == OP_DATA);
            bcnt_d    = '0;
            started_d = 1'b0;
            state_d   = S_SHIFT;
          end
          OP_DELAY: begin
            dly_d = operand;
            if (operand == '0) begin
              pc_d    = pc_q + PC_ONE;
              state_d = S_FETCH;
            end else begin
              state_d = S_DELAY;
            end
          end
          default: begin
            state_d = S_HALT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cs_d    = 1'b1;
          end
        endcase
      end

      // CS drops on the first launch edge; bits are counted on sample edges
      // only once the frame has opened, and the frame closes on the launch
      // edge that follows the last sample.
      S_SHIFT: begin
        if (pos_ev) begin
          if (started_q && (bcnt_q != BCNT_FULL)) begin
            bcnt_d = bcnt_q + BCNT_ONE;
          end
        end else if (neg_ev) begin
          if (!started_q) begin
            started_d = 1'b1;
            cs_d      = 1'b0;
            mosi_d    = shreg_q[DATA_BITS-1];
            shreg_d   = shreg_q << 1;
          end else if (bcnt_q == BCNT_FULL) begin
            cs_d    = 1'b1;
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end else begin
            mosi_d  = shreg_q[DATA_BITS-1];
            shreg_d = shreg_q << 1;
          end
        end
      end

      S_DELAY: begin
        if (pos_ev) begin
          dly_d = dly_q - DLY_ONE;
          if (dly_q == DLY_ONE) begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
        end
      end

      S_HALT: begin
        cs_d = 1'b1;
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and pin registers; cs returns high the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      bcnt_q    <= '0;
      started_q <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      dc_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      bcnt_q    <= bcnt_d;
      started_q <= started_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
      dc_q      <= dc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Datapath registers: always loaded before use, so no reset needed.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    dly_q   <= dly_d;
  end

  assign mosi = mosi_q;
  assign cs   = cs_q;
  assign dc   = dc_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pc   = pc_q;

endmodule

// File: tb/tb_spi_lcd_sequencer.sv
module tb_spi_lcd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk_pos_edge, sclk_neg_edge;
  logic       start, wr_en;
  logic [7:0] wr_addr;
  logic [9:0] wr_data;
  logic       mosi, cs, dc, busy, done;
  logic [7:0] pc;

  logic       start_w, wr_en_w;
  logic [1:0] wr_addr_w;
  logic       mosi_w, cs_w, dc_w, busy_w, done_w;
  logic [1:0] pc_w;

  int ph;
  int n_checks = 0;
  int n_fail   = 0;

  // Frame monitor results
  logic [7:0] byte_q[$];
  int         len_q[$];
  int         nb_q[$];
  logic       dcs_q[$];
  logic [7:0] cur;
  int         nbits, lowlen;
  logic       in_low, cur_dc;

  spi_lcd_sequencer #(.MEM_BITS(10), .ADDR_WIDTH(8), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .sclk_pos_edge(sclk_pos_edge), .sclk_neg_edge(sclk_neg_edge),
    .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mosi(mosi), .cs(cs), .dc(dc), .busy(busy), .done(done), .pc(pc)
  );

  spi_lcd_sequencer #(.MEM_BITS(10), .ADDR_WIDTH(2), .DATA_BITS(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .sclk_pos_edge(sclk_pos_edge), .sclk_neg_edge(sclk_neg_edge),
    .start(start_w), .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data),
    .mosi(mosi_w), .cs(cs_w), .dc(dc_w), .busy(busy_w), .done(done_w), .pc(pc_w)
  );

  always #5 clk = ~clk;

  // SPI strobes: period 8 clks, sample edge at phase 0, launch edge at phase 4
  initial begin
    ph = 0;
    sclk_pos_edge = 1'b0;
    sclk_neg_edge = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 8;
      sclk_pos_edge = (ph == 0);
      sclk_neg_edge = (ph == 4);
    end
  end

  // Collect each CS-low window: byte seen on sample edges, length, bit count, dc
  initial begin
    in_low = 1'b0; nbits = 0; lowlen = 0; cur = '0; cur_dc = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        in_low = 1'b0;
      end else if (!cs) begin
        if (!in_low) begin
          in_low = 1'b1; nbits = 0; lowlen = 0; cur = '0;
        end
        lowlen++;
        cur_dc = dc;
        if (sclk_pos_edge) begin
          cur = {cur[6:0], mosi};
          nbits++;
        end
      end else if (in_low) begin
        in_low = 1'b0;
        byte_q.push_back(cur);
        len_q.push_back(lowlen);
        nb_q.push_back(nbits);
        dcs_q.push_back(cur_dc);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    byte_q.delete(); len_q.delete(); nb_q.delete(); dcs_q.delete();
  endtask

  task automatic mem_wr(input logic [7:0] a, input logic [9:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic mem_wr_w(input logic [1:0] a, input logic [9:0] d);
    @(negedge clk);
    wr_en_w = 1'b1; wr_addr_w = a; wr_data = d;
    @(negedge clk);
    wr_en_w = 1'b0;
  endtask

  // Start aligned to strobe phase 2 so fetch/decode never coincide with a sample edge
  task automatic pulse_start();
    @(negedge clk); #1;
    while (ph != 2) begin
      @(negedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output int npos);
    cyc = 0; npos = 0;
    while (!done && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      if (sclk_pos_edge) npos++;
    end
  endtask

  function automatic logic [7:0] byte_at(input int i);
    return (i < byte_q.size()) ? byte_q[i] : 8'h00;
  endfunction

  function automatic int len_at(input int i);
    return (i < len_q.size()) ? len_q[i] : -1;
  endfunction

  function automatic int nb_at(input int i);
    return (i < nb_q.size()) ? nb_q[i] : -1;
  endfunction

  function automatic logic dc_at(input int i);
    return (i < dcs_q.size()) ? dcs_q[i] : 1'bx;
  endfunction

  initial begin
    int cyc, npos, prev;
    int exp_pc[6];
    exp_pc = '{1, 2, 3, 0, 1, 2};

    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start_w = 1'b0; wr_en_w = 1'b0; wr_addr_w = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs",   cs,   1);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_dc",   dc,   0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pc",   pc,   0);
    check_eq("rst_pc_w", pc_w, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // CMD A5 then HALT
    mem_wr(8'd0, 10'h0A5);
    mem_wr(8'd1, 10'h3C0);
    clear_mon();
    pulse_start();
    check_eq("cmd_busy", busy, 1);
    wait_done(2000, cyc, npos);
    check_eq("cmd_done",   done, 1);
    check_eq("cmd_nbytes", byte_q.size(), 1);
    check_eq("cmd_byte",   byte_at(0), 8'hA5);
    check_eq("cmd_cslen",  len_at(0), 64);
    check_eq("cmd_nbits",  nb_at(0), 8);
    check_eq("cmd_dc",     dc_at(0), 0);
    check_eq("cmd_pc",     pc, 1);
    check_eq("cmd_idle",   busy, 0);
    check_eq("cmd_cs_end", cs, 1);
    check_eq("cmd_mosi_hold", mosi, 1);

    // DATA 3C, DATA FF, HALT
    mem_wr(8'd0, 10'h13C);
    mem_wr(8'd1, 10'h1FF);
    mem_wr(8'd2, 10'h300);
    clear_mon();
    pulse_start();
    check_eq("data_done_clr", done, 0);
    wait_done(2000, cyc, npos);
    check_eq("data_done",   done, 1);
    check_eq("data_nbytes", byte_q.size(), 2);
    check_eq("data_b0",     byte_at(0), 8'h3C);
    check_eq("data_b1",     byte_at(1), 8'hFF);
    check_eq("data_dc0",    dc_at(0), 1);
    check_eq("data_dc1",    dc_at(1), 1);
    check_eq("data_len1",   len_at(1), 64);
    check_eq("data_pc",     pc, 2);

    // DELAY 5 then HALT
    mem_wr(8'd0, 10'h205);
    mem_wr(8'd1, 10'h300);
    clear_mon();
    pulse_start();
    wait_done(2000, cyc, npos);
    check_eq("dly5_done",  done, 1);
    check_eq("dly5_npos",  npos, 5);
    check_eq("dly5_nocs",  byte_q.size(), 0);
    check_eq("dly5_pc",    pc, 1);

    // DELAY 0: straight through
    mem_wr(8'd0, 10'h200);
    clear_mon();
    pulse_start();
    wait_done(2000, cyc, npos);
    check_eq("dly0_done", done, 1);
    check_eq("dly0_cyc",  cyc, 4);
    check_eq("dly0_npos", npos, 0);
    check_eq("dly0_nocs", byte_q.size(), 0);

    // Write and start while busy are both ignored
    mem_wr(8'd0, 10'h0A5);
    mem_wr(8'd1, 10'h300);
    clear_mon();
    pulse_start();
    repeat (10) @(posedge clk);
    mem_wr(8'd1, 10'h0FF);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(2000, cyc, npos);
    check_eq("lock_done",   done, 1);
    check_eq("lock_nbytes", byte_q.size(), 1);
    check_eq("lock_byte",   byte_at(0), 8'hA5);
    check_eq("lock_pc",     pc, 1);

    // Reset in the middle of a byte
    clear_mon();
    pulse_start();
    cyc = 0;
    while (cs && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq("midrst_cs_low", cs, 0);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_cs",   cs, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_pc",   pc, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_mon();

    // Program survives reset
    pulse_start();
    wait_done(2000, cyc, npos);
    check_eq("rerun_nbytes", byte_q.size(), 1);
    check_eq("rerun_byte",   byte_at(0), 8'hA5);

    // 4-entry program without HALT: pc wraps and keeps running
    mem_wr_w(2'd0, 10'h200);
    mem_wr_w(2'd1, 10'h200);
    mem_wr_w(2'd2, 10'h200);
    mem_wr_w(2'd3, 10'h200);
    @(negedge clk); start_w = 1'b1;
    @(negedge clk); start_w = 1'b0;
    prev = int'(pc_w);
    for (int k = 0; k < 6; k++) begin
      cyc = 0;
      while (int'(pc_w) == prev && cyc < 50) begin
        @(posedge clk); #1; cyc++;
      end
      check_eq($sformatf("wrap_pc%0d", k), pc_w, exp_pc[k]);
      prev = int'(pc_w);
    end
    check_eq("wrap_busy", busy_w, 1);
    check_eq("wrap_done", done_w, 0);
    check_eq("wrap_cs",   cs_w, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
